// File: rtl/fp_addsub_acc_pipe.sv
// Two-stage, valid/ready pipelined saturating fixed-point add/sub/accumulate unit
// with a running accumulator, a sticky saturation flag and a saturating event counter.
module fp_addsub_acc_pipe #(
  parameter int WIDTH      = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     arg1,
  input  logic [WIDTH-1:0]     arg2,
  input  logic [1:0]           op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 ovrflw,
  input  logic                 clr_sticky,
  output logic                 sat_sticky,
  output logic [CNT_WIDTH-1:0] ovf_count
);

  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  localparam logic [WIDTH-1:0]     MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]     MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = {CNT_WIDTH{1'b1}};

  logic                 s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]     s1_a_q, s1_a_d;
  logic [WIDTH-1:0]     s1_b_q, s1_b_d;
  logic [1:0]           s1_op_q, s1_op_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 ovrflw_q, ovrflw_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic                 sat_sticky_q, sat_sticky_d;
  logic [CNT_WIDTH-1:0] ovf_count_q, ovf_count_d, cnt_base;

  logic             s1_en, s2_en, s2_load, sat_event;
  logic [WIDTH:0]   op_x, op_y, raw;
  logic [WIDTH-1:0] sat_val;
  logic             sat_ovf;

  assign s2_en    = !s2_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign s2_load  = s1_valid_q && s2_en;
  assign in_ready = s1_en;

  // Operands are sign-extended by one bit so the true sum/difference always fits;
  // saturation is then a check of the top two bits of the WIDTH+1 result.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    op_x = {s1_a_q[WIDTH-1], s1_a_q};
    op_y = {s1_b_q[WIDTH-1], s1_b_q};
    if (s1_op_q == OP_ACC) begin
      op_x = {acc_q[WIDTH-1], acc_q};
      op_y = {s1_a_q[WIDTH-1], s1_a_q};
    end else if (s1_op_q == OP_LOAD) begin
      op_y = '0;
    end
    raw = (s1_op_q == OP_SUB) ? (op_x - op_y) : (op_x + op_y);
    sat_ovf = raw[WIDTH] ^ raw[WIDTH-1];
    sat_val = raw[WIDTH-1:0];
    if (sat_ovf) sat_val = raw[WIDTH] ? MIN_NEG : MAX_POS;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    if (s1_en) begin
      s1_valid_d = in_valid;
      s1_a_d     = arg1;
      s1_b_d     = arg2;
      s1_op_d    = op;
    end

    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    ovrflw_d   = ovrflw_q;
    acc_d      = acc_q;
    if (s2_en) s2_valid_d = s1_valid_q;
    if (s2_load) begin
      result_d = sat_val;
      ovrflw_d = sat_ovf;
      if (s1_op_q[1]) acc_d = sat_val;
    end

    // A clear takes effect first, so an event in the same cycle still counts as one.
    sat_event    = s2_load && sat_ovf;
    cnt_base     = clr_sticky ? '0 : ovf_count_q;
    sat_sticky_d = (sat_sticky_q && !clr_sticky) || sat_event;
    ovf_count_d  = cnt_base;
    if (sat_event && cnt_base != CNT_FULL) ovf_count_d = cnt_base + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only; all registers here are
  // small control/datapath flops, so every one of them is reset (no memories involved).
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_op_q      <= '0;
      s2_valid_q   <= 1'b0;
      result_q     <= '0;
      ovrflw_q     <= 1'b0;
      acc_q        <= '0;
      sat_sticky_q <= 1'b0;
      ovf_count_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_op_q      <= s1_op_d;
      s2_valid_q   <= s2_valid_d;
      result_q     <= result_d;
      ovrflw_q     <= ovrflw_d;
      acc_q        <= acc_d;
      sat_sticky_q <= sat_sticky_d;
      ovf_count_q  <= ovf_count_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign result     = result_q;
  assign ovrflw     = ovrflw_q;
  assign sat_sticky = sat_sticky_q;
  assign ovf_count  = ovf_count_q;

endmodule

// File: tb/tb_fp_addsub_acc_pipe.sv
// Self-checking bench for fp_addsub_acc_pipe: directed spec scenarios plus a randomized
// stream scored against an integer-arithmetic reference model.
module tb_fp_addsub_acc_pipe;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        in_valid, in_ready, out_valid, out_ready, ovrflw, clr_sticky, sat_sticky;
  logic [15:0] arg1, arg2, result;
  logic [1:0]  op;
  logic [CNT_W-1:0] ovf_count;

  logic        v24, rdy24, ov24, ovf24, st24;
  logic [23:0] a24, b24, r24;
  logic [7:0]  cnt24;

  always #5 clk_in = ~clk_in;

  fp_addsub_acc_pipe #(.WIDTH(16), .FRAC_WIDTH(8), .CNT_WIDTH(CNT_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .in_valid(in_valid), .in_ready(in_ready),
    .arg1(arg1), .arg2(arg2), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovrflw(ovrflw), .clr_sticky(clr_sticky),
    .sat_sticky(sat_sticky), .ovf_count(ovf_count)
  );

  fp_addsub_acc_pipe #(.WIDTH(24), .FRAC_WIDTH(12), .CNT_WIDTH(8)) dut24 (
    .clk_in(clk_in), .rst_in(rst_in), .in_valid(v24), .in_ready(rdy24),
    .arg1(a24), .arg2(b24), .op(2'b00), .out_valid(ov24), .out_ready(1'b1),
    .result(r24), .ovrflw(ovf24), .clr_sticky(1'b0),
    .sat_sticky(st24), .ovf_count(cnt24)
  );

  typedef struct packed { logic [15:0] r; logic o; } exp_t;
  typedef struct packed { logic [1:0] op; logic [15:0] a; logic [15:0] b; } beat_t;

  exp_t  exp_q[$];
  beat_t pend[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    m_acc    = 0;
  int    m_cnt    = 0;
  logic  m_sticky = 1'b0;
  logic  last_acc, saw_block, hold;
  logic [15:0] held_r;
  logic        held_o;
  int    cycles;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Reference: exact integer arithmetic, then clip to the 16-bit signed range.
  task automatic model_beat(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    int sx, sy, raw;
    exp_t e;
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      2'b00:   raw = sx + sy;
      2'b01:   raw = sx - sy;
      2'b10:   raw = m_acc + sx;
      default: raw = sx;
    endcase
    if (raw > 32767)       begin e.r = 16'h7FFF;   e.o = 1'b1; end
    else if (raw < -32768) begin e.r = 16'h8000;   e.o = 1'b1; end
    else                   begin e.r = raw[15:0];  e.o = 1'b0; end
    if (o[1]) m_acc = $signed(e.r);
    if (e.o) begin
      m_sticky = 1'b1;
      if (m_cnt < CNT_MAX) m_cnt++;
    end
    exp_q.push_back(e);
  endtask

  // One clock: drive, sample just before the edge, score outputs, advance to edge+1.
  task automatic cyc(input logic v, input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                     input logic ordy, input logic clr);
    exp_t e;
    in_valid = v; op = o; arg1 = x; arg2 = y; out_ready = ordy; clr_sticky = clr;
    #1;
    last_acc = v & in_ready;
    if (v && !in_ready) saw_block = 1'b1;
    if (hold) begin
      check("stall_result_stable", result, held_r);
      check("stall_ovrflw_stable", ovrflw, held_o);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("spurious_out", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("result", result, e.r);
        check("ovrflw", ovrflw, e.o);
      end
    end
    hold   = out_valid & !out_ready;
    held_r = result;
    held_o = ovrflw;
    if (last_acc) model_beat(o, x, y);
    @(posedge clk_in);
    #1;
    in_valid = 1'b0;
    clr_sticky = 1'b0;
  endtask

  task automatic stream(input int stall_from, input int stall_len, input logic rnd, output int ncyc);
    int n;
    logic ordy, v;
    n = 0;
    saw_block = 1'b0;
    while ((pend.size() > 0 || exp_q.size() > 0) && n < 5000) begin
      ordy = rnd ? ($urandom_range(0, 3) != 0) : !(n >= stall_from && n < stall_from + stall_len);
      v = (pend.size() > 0) && (!rnd || $urandom_range(0, 4) != 0);
      if (v) cyc(1'b1, pend[0].op, pend[0].a, pend[0].b, ordy, 1'b0);
      else   cyc(1'b0, 2'b00, 16'h0, 16'h0, ordy, 1'b0);
      if (v && last_acc) void'(pend.pop_front());
      n++;
    end
    ncyc = n;
    check("drained", pend.size() + exp_q.size(), 0);
  endtask

  function automatic logic [15:0] rnd_word();
    case ($urandom_range(0, 3))
      0:       return 16'h7F00 + 16'($urandom_range(0, 255));
      1:       return 16'h8000 + 16'($urandom_range(0, 255));
      default: return 16'($urandom());
    endcase
  endfunction

  initial begin
    beat_t bt;
    hold = 1'b0;
    in_valid = 0; out_ready = 1; clr_sticky = 0; op = 0; arg1 = 0; arg2 = 0;
    v24 = 0; a24 = 0; b24 = 0;
    rst_in = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_result", result, 0);
    check("rst_sticky", sat_sticky, 0);
    check("rst_count", ovf_count, 0);
    #11 rst_in = 1'b1;
    @(posedge clk_in); #1;

    // 1: positive saturation and 2-cycle latency
    cyc(1'b1, 2'b00, 16'h7F00, 16'h0200, 1'b1, 1'b0);
    check("t1_accept", last_acc, 1);
    check("t1_lat_cycle1", out_valid, 0);
    cyc(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0);
    check("t1_lat_cycle2", out_valid, 1);
    check("t1_result", result, 16'h7FFF);
    check("t1_ovrflw", ovrflw, 1);
    check("t1_sticky", sat_sticky, 1);
    check("t1_count", ovf_count, 1);
    cyc(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0);

    // 2: negative saturation, SUB of MIN, plain add
    pend.push_back('{2'b01, 16'h8000, 16'h0001});
    pend.push_back('{2'b01, 16'h0000, 16'h8000});
    pend.push_back('{2'b00, 16'h0180, 16'hFF00});
    stream(0, 0, 1'b0, cycles);

    // 3: back-to-back LOAD/ACC chain, no bubbles (4 beats + 2 latency)
    pend.push_back('{2'b11, 16'h7000, 16'h1234});
    pend.push_back('{2'b10, 16'h0800, 16'h0000});
    pend.push_back('{2'b10, 16'h0800, 16'h0000});
    pend.push_back('{2'b10, 16'hF000, 16'h0000});
    stream(0, 0, 1'b0, cycles);
    check("t3_no_bubbles", cycles, 6);

    // 4: backpressure mid-stream
    for (int i = 0; i < 6; i++) begin
      bt.op = 2'b00; bt.a = 16'(i * 16'h0111); bt.b = 16'h0010;
      pend.push_back(bt);
    end
    stream(2, 3, 1'b0, cycles);
    check("t4_in_ready_low", saw_block, 1);

    // 5: counter saturation, then clear coincident with an event
    cyc(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b1);
    m_cnt = 0; m_sticky = 1'b0;
    check("t5_clr_sticky", sat_sticky, 0);
    check("t5_clr_count", ovf_count, 0);
    for (int i = 0; i < 5; i++) pend.push_back('{2'b00, 16'h7F00, 16'h0200});
    stream(0, 0, 1'b0, cycles);
    check("t5_count_sat", ovf_count, m_cnt);
    check("t5_count_is_max", ovf_count, 3);
    cyc(1'b1, 2'b00, 16'h8000, 16'hFFFF, 1'b1, 1'b0);
    cyc(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b1);
    check("t5_coinc_sticky", sat_sticky, 1);
    check("t5_coinc_count", ovf_count, 1);
    cyc(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0);
    m_cnt = 1; m_sticky = 1'b1;

    // Randomized stream with random gaps and stalls
    for (int i = 0; i < 300; i++) begin
      bt.op = 2'($urandom_range(0, 3)); bt.a = rnd_word(); bt.b = rnd_word();
      pend.push_back(bt);
    end
    stream(0, 0, 1'b1, cycles);
    check("rand_sticky", sat_sticky, m_sticky);
    check("rand_count", ovf_count, m_cnt);

    // 6: async reset with two beats in flight
    cyc(1'b1, 2'b10, 16'h7F00, 16'h0, 1'b1, 1'b0);
    cyc(1'b1, 2'b00, 16'h7F00, 16'h7F00, 1'b1, 1'b0);
    check("t6_inflight", out_valid, 1);
    #2 rst_in = 1'b0;
    #1;
    check("t6_out_valid", out_valid, 0);
    check("t6_sticky", sat_sticky, 0);
    check("t6_count", ovf_count, 0);
    check("t6_in_ready", in_ready, 1);
    exp_q.delete();
    m_acc = 0; m_cnt = 0; m_sticky = 1'b0; hold = 1'b0;
    #2 rst_in = 1'b1;
    @(posedge clk_in); #1;
    pend.push_back('{2'b10, 16'h0123, 16'h0000});
    stream(0, 0, 1'b0, cycles);

    // W=24 instance
    v24 = 1'b1; a24 = 24'h7FF000; b24 = 24'h002000;
    @(posedge clk_in); #1;
    v24 = 1'b0;
    @(posedge clk_in); #1;
    check("w24_out_valid", ov24, 1);
    check("w24_result", r24, 24'h7FFFFF);
    check("w24_ovrflw", ovf24, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
